// File: rtl/cap_integrator_mc_pkg.sv
// Shared types and defaults for the multi-channel
// capacitor integrator.
package cap_integrator_pkg;

  typedef enum logic [1:0] {
    M_INTEGRATE = 2'b00,
    M_HOLD      = 2'b01,
    M_DISCHARGE = 2'b10,
    M_CLEAR     = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PROC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int N_CH_DEF       = 4;
  localparam int IW_DEF         = 16;
  localparam int VW_DEF         = 24;
  localparam int GAIN_SHIFT_DEF = 4;
  localparam int LEAK_SHIFT_DEF = 8;

endpackage

// File: rtl/cap_integrator_mc_sat_step.sv
// One-channel update: scale/add with clamp,
// leak, hold and clear. Purely combinational.
module cap_sat_step
  import cap_integrator_pkg::*;
#(
  parameter int IW         = IW_DEF,
  parameter int VW         = VW_DEF,
  parameter int GAIN_SHIFT = GAIN_SHIFT_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
  input  logic signed [VW-1:0] v,
  input  logic signed [IW-1:0] cur,
  input  mode_t                mode,
  input  logic                 sat_in,
  output logic signed [VW-1:0] v_next,
  output logic                 sat_next
);

  localparam logic signed [VW-1:0] VMAX =
    {1'b0, {(VW-1){1'b1}}};
  localparam logic signed [VW-1:0] VMIN =
    {1'b1, {(VW-1){1'b0}}};

  logic signed [VW:0]   inc;
  logic signed [VW:0]   sum;
  logic signed [VW-1:0] leak;

  // One guard bit on the sum exposes overflow
  // as a mismatch of the top two bits.
  always_comb begin
    inc      = {{(VW+1-IW){cur[IW-1]}}, cur}
               << GAIN_SHIFT;
    sum      = {v[VW-1], v} + inc;
    leak     = v >>> LEAK_SHIFT;
    v_next   = v;
    sat_next = sat_in;
    unique case (mode)
      M_INTEGRATE: begin
        if (sum[VW] != sum[VW-1]) begin
          v_next   = sum[VW] ? VMIN : VMAX;
          sat_next = 1'b1;
        end else begin
          v_next = sum[VW-1:0];
        end
      end
      M_HOLD: begin
        v_next = v;
      end
      M_DISCHARGE: begin
        v_next = v - leak;
      end
      M_CLEAR: begin
        v_next   = '0;
        sat_next = 1'b0;
      end
      default: begin
        v_next = v;
      end
    endcase
  end

endmodule

// File: rtl/cap_integrator_mc.sv
// Multi-channel capacitor integrator; channels
// are updated serially through one datapath.
module cap_integrator_mc
  import cap_integrator_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int IW         = IW_DEF,
  parameter int VW         = VW_DEF,
  parameter int GAIN_SHIFT = GAIN_SHIFT_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CH*IW-1:0]   i_in,
  input  logic [1:0]           mode,
  output logic [N_CH*VW-1:0]   vout,
  output logic                 out_valid,
  output logic [N_CH-1:0]      sat,
  output logic                 busy
);

  localparam int IDXW =
    (N_CH > 1) ? $clog2(N_CH) : 1;

  if (VW < IW + GAIN_SHIFT + 1) begin : g_vw_chk
    $error("cap_integrator_mc: VW too small");
  end

  state_t               state;
  state_t               state_nx;
  logic [IDXW-1:0]      idx;
  logic [N_CH*IW-1:0]   cur_lat;
  mode_t                mode_lat;
  logic signed [VW-1:0] acc [N_CH];
  logic signed [VW-1:0] v_sel;
  logic signed [VW-1:0] v_new;
  logic signed [IW-1:0] cur_sel;
  logic                 s_new;
  logic                 take;
  logic                 last;

  assign take    = in_valid && in_ready;
  assign last    = (idx == IDXW'(N_CH-1));
  assign v_sel   = acc[idx];
  assign cur_sel = cur_lat[idx*IW +: IW];

  cap_sat_step #(
    .IW         (IW),
    .VW         (VW),
    .GAIN_SHIFT (GAIN_SHIFT),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_step (
    .v        (v_sel),
    .cur      (cur_sel),
    .mode     (mode_lat),
    .sat_in   (sat[idx]),
    .v_next   (v_new),
    .sat_next (s_new)
  );

  // Next state and handshake outputs.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = PROC;
      end
      PROC: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Latching, per-channel update and snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      cur_lat   <= '0;
      mode_lat  <= M_HOLD;
      sat       <= '0;
      vout      <= '0;
      out_valid <= 1'b0;
      for (int k = 0; k < N_CH; k++)
        acc[k] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (take) begin
        cur_lat  <= i_in;
        mode_lat <= mode_t'(mode);
        idx      <= '0;
      end
      if (state == PROC) begin
        acc[idx] <= v_new;
        sat[idx] <= s_new;
        idx      <= last ? '0 : idx + 1'b1;
      end
      if (state == DONE) begin
        for (int k = 0; k < N_CH; k++)
          vout[k*VW +: VW] <= acc[k];
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cap_integrator_mc.md
CAP_INTEGRATOR_MC -- requirements
Module: cap_integrator_mc

Interface
REQ-001 Parameter N_CH, default 4, number of capacitor channels.
REQ-002 Parameter IW, default 16, signed width of each input current sample.
REQ-003 Parameter VW, default 24, signed width of each voltage accumulator; VW >= IW+GAIN_SHIFT+1 SHALL be checked at elaboration.
REQ-004 Parameter GAIN_SHIFT, default 4, left shift modelling dt/C scaling.
REQ-005 Parameter LEAK_SHIFT, default 8, right shift setting the discharge fraction.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 in_valid  input  1  sample vector and mode are presented.
REQ-009 in_ready  output  1  block can accept a sample vector.
REQ-010 i_in  input  N_CH*IW  packed signed currents; channel k in bits [k*IW +: IW].
REQ-011 mode  input  2  operation for this sample: 00 INTEGRATE, 01 HOLD, 10 DISCHARGE, 11 CLEAR.
REQ-012 vout  output  N_CH*VW  packed signed voltages; channel k in bits [k*VW +: VW].
REQ-013 out_valid  output  1  one-cycle pulse when vout holds a new result.
REQ-014 sat  output  N_CH  sticky per-channel saturation flags.
REQ-015 busy  output  1  high while a sample vector is being processed.

Function
REQ-016 FSM states SHALL be IDLE, PROC, DONE; in_ready=1 only in IDLE; busy=1 in PROC and DONE.
REQ-017 Transfer on in_valid&&in_ready; i_in and mode latched; IDLE->PROC with channel index 0.
REQ-018 PROC SHALL update one channel per cycle through a single shared datapath, index 0..N_CH-1; after index N_CH-1, go to DONE.
REQ-019 DONE SHALL last one cycle: internal accumulators copied to vout, out_valid=1, then return to IDLE unconditionally.
REQ-020 out_valid SHALL rise N_CH+1 cycles after the accepting edge; throughput SHALL be one vector per N_CH+2 cycles.
REQ-021 vout SHALL change only in DONE, giving a coherent all-channel snapshot.
REQ-022 INTEGRATE: v_next = v + (sext(i) <<< GAIN_SHIFT), computed in VW+1 bits.
REQ-023 Result above 2^(VW-1)-1 or below -2^(VW-1) SHALL clamp to that bound and set sat[k]; an exact in-range result SHALL NOT set sat.
REQ-024 HOLD: accumulators unchanged; handshake, timing and out_valid as for INTEGRATE.
REQ-025 DISCHARGE: v_next = v - (v >>> LEAK_SHIFT), arithmetic (floor) shift, never saturates.
REQ-026 CLEAR: v_next = 0 and sat[k] cleared for each channel.
REQ-027 in_valid while not in IDLE SHALL be ignored and SHALL NOT corrupt latched data.
REQ-028 sat bits SHALL be cleared only by CLEAR or rst.

Reset
REQ-029 rst SHALL, at the next rising edge from any state (including mid-PROC), force IDLE, all accumulators and vout to 0, sat to 0, out_valid 0, busy 0, in_ready 1.
REQ-030 A vector partially processed when rst asserts SHALL be discarded with no out_valid pulse.

Structure
REQ-031 Package cap_integrator_pkg SHALL hold the mode enum, the FSM state enum and default parameter constants.
REQ-032 Sub-module cap_sat_step SHALL implement the per-channel scale/add/leak/clamp datapath (combinational), instanced once.

Verification (N_CH=4, IW=16, VW=24, GAIN_SHIFT=4, LEAK_SHIFT=8)
REQ-033 After rst, 10 INTEGRATE vectors of i=100 on all channels -> vout=16000 each, 10 out_valid pulses, each 5 cycles after acceptance, sat=0.
REQ-034 ch0 i=32767 and ch1 i=-32768 INTEGRATE x17 -> after 16: ch0=8388352, ch1=-8388608, sat=0; after 17: ch0=8388607, ch1=-8388608, sat[1:0]=11.
REQ-035 From ch0=16000 and ch1=-16000: DISCHARGE -> 15938 and -15937; HOLD -> values unchanged, out_valid still pulses.
REQ-036 CLEAR after saturation -> all vout=0 and sat=0; a following INTEGRATE of i=1 -> vout=16.
REQ-037 rst asserted on the second PROC cycle -> next cycle in_ready=1, vout=0, no out_valid pulse; in_valid held high during PROC/DONE -> exactly one vector accepted per N_CH+2 cycles.
